// File: rtl/mux_gate_unit_if.sv
// Operand/result handshake bundle for mux_gate_unit.
// The master side drives operands and sink readiness; the slave side is the unit itself.
interface mux_gate_unit_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;
    logic [2:0]         y_op;
    logic [COUNT_W-1:0] op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, y_op, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, y_op, op_count
    );
endinterface

// File: rtl/mux_gate_unit.sv
// Two-stage valid/ready gate-function engine: eight bitwise functions built only from 2:1 muxes,
// with backpressure and a saturating count of delivered results.
module mux_gate_unit #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input logic            clk,
    input logic            rst,
    mux_gate_unit_if.slave bus
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    function automatic logic mux2(input logic sel, input logic x1, input logic x0);
        return sel ? x1 : x0;
    endfunction

    function automatic logic mux_not(input logic x);
        return mux2(x, 1'b0, 1'b1);
    endfunction

    // Every gate and the opcode tree are pure 2:1 mux compositions.
    function automatic logic gate_bit(input logic [2:0] sel, input logic ai, input logic bi);
        logic g_and;
        logic g_or;
        logic g_not;
        logic g_nand;
        logic g_nor;
        logic g_xor;
        logic g_xnor;
        logic g_buf;
        logic m00;
        logic m01;
        logic m10;
        logic m11;
        logic n0;
        logic n1;
        g_and  = mux2(bi, ai, 1'b0);
        g_or   = mux2(ai, 1'b1, bi);
        g_not  = mux_not(ai);
        g_nand = mux_not(g_and);
        g_nor  = mux_not(g_or);
        g_xor  = mux2(bi, g_not, ai);
        g_xnor = mux2(bi, ai, g_not);
        g_buf  = ai;
        m00    = mux2(sel[0], g_or,   g_and);
        m01    = mux2(sel[0], g_nand, g_not);
        m10    = mux2(sel[0], g_xor,  g_nor);
        m11    = mux2(sel[0], g_buf,  g_xnor);
        n0     = mux2(sel[1], m01, m00);
        n1     = mux2(sel[1], m11, m10);
        return mux2(sel[2], n1, n0);
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + COUNT_W'(1);
    endfunction

    logic               vld_p1_q;
    logic               vld_p1_d;
    logic [WIDTH-1:0]   a_p1_q;
    logic [WIDTH-1:0]   b_p1_q;
    logic [2:0]         op_p1_q;

    logic               vld_p2_q;
    logic               vld_p2_d;
    logic [WIDTH-1:0]   y_p2_q;
    logic [WIDTH-1:0]   y_p2_d;
    logic [2:0]         op_p2_q;
    logic [2:0]         op_p2_d;
    logic [WIDTH-1:0]   y_d;

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    logic stall;
    logic in_ready;
    logic accept;
    logic deliver;

    always_comb begin
        stall    = vld_p2_q && !bus.out_ready;
        in_ready = !stall || !vld_p1_q;
        accept   = bus.in_valid && in_ready;
        deliver  = vld_p2_q && bus.out_ready;
    end

    always_comb begin
        y_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y_d[i] = gate_bit(op_p1_q, a_p1_q[i], b_p1_q[i]);
        end
    end

    always_comb begin
        vld_p1_d = in_ready ? bus.in_valid : vld_p1_q;
        vld_p2_d = stall ? vld_p2_q : vld_p1_q;
        // y keeps its last value when a bubble passes through.
        y_p2_d   = (!stall && vld_p1_q) ? y_d : y_p2_q;
        op_p2_d  = (!stall && vld_p1_q) ? op_p1_q : op_p2_q;
        cnt_d    = deliver ? sat_inc(cnt_q) : cnt_q;
    end

    // ---- S1: operand capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1_q  <= bus.a;
            b_p1_q  <= bus.b;
            op_p1_q <= bus.op;
        end
    end

    // ---- S2: gate result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
            op_p2_q  <= '0;
            cnt_q    <= '0;
        end else begin
            vld_p2_q <= vld_p2_d;
            y_p2_q   <= y_p2_d;
            op_p2_q  <= op_p2_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2_q;
    assign bus.y         = y_p2_q;
    assign bus.y_op      = op_p2_q;
    assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_mux_gate_unit.sv
// Bench for mux_gate_unit: four builds (WIDTH 8/1/32, COUNT_W 16/2) share one stimulus stream
// and are scored against a plain-operator reference model with an in-order queue.
module tb_mux_gate_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    int tests = 0;
    int fails = 0;
    int ndel  = 0;
    int cycle = 0;
    logic hs_rdy;
    logic hs_acc;
    logic stalled = 1'b0;
    logic [44:0] held;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          t;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    mux_gate_unit_if #(.WIDTH(8),  .COUNT_W(16)) bus8  ();
    mux_gate_unit_if #(.WIDTH(1),  .COUNT_W(16)) bus1  ();
    mux_gate_unit_if #(.WIDTH(32), .COUNT_W(16)) bus32 ();
    mux_gate_unit_if #(.WIDTH(8),  .COUNT_W(2))  busc  ();

    assign bus8.in_valid   = in_valid;
    assign bus8.op         = op;
    assign bus8.a          = a[7:0];
    assign bus8.b          = b[7:0];
    assign bus8.out_ready  = out_ready;
    assign bus1.in_valid   = in_valid;
    assign bus1.op         = op;
    assign bus1.a          = a[0];
    assign bus1.b          = b[0];
    assign bus1.out_ready  = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.op        = op;
    assign bus32.a         = a;
    assign bus32.b         = b;
    assign bus32.out_ready = out_ready;
    assign busc.in_valid   = in_valid;
    assign busc.op         = op;
    assign busc.a          = a[7:0];
    assign busc.b          = b[7:0];
    assign busc.out_ready  = out_ready;

    mux_gate_unit #(.WIDTH(8),  .COUNT_W(16)) u8  (.clk(clk), .rst(rst), .bus(bus8));
    mux_gate_unit #(.WIDTH(1),  .COUNT_W(16)) u1  (.clk(clk), .rst(rst), .bus(bus1));
    mux_gate_unit #(.WIDTH(32), .COUNT_W(16)) u32 (.clk(clk), .rst(rst), .bus(bus32));
    mux_gate_unit #(.WIDTH(8),  .COUNT_W(2))  uc  (.clk(clk), .rst(rst), .bus(busc));

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~x;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return x ^ z;
            3'd6:    return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    function automatic logic [44:0] snap();
        return {bus32.y, bus8.y, bus1.y, bus8.y_op, bus8.out_valid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: called just after a negedge with inputs already set.
    task automatic cyc();
        logic acc;
        logic del;
        logic [31:0] ey;
        sb_t it;
        #1;
        hs_rdy = bus8.in_ready;
        acc = in_valid && bus8.in_ready;
        del = bus8.out_valid && out_ready;
        chk("ctl_match",
            64'({bus1.in_ready, bus32.in_ready, busc.in_ready, bus1.out_valid, bus32.out_valid, busc.out_valid}),
            64'({{3{bus8.in_ready}}, {3{bus8.out_valid}}}));
        if (!rst && stalled) chk("stall_hold", 64'(snap()), 64'(held));
        if (!rst && del) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(1), 64'(0));
            end else begin
                it = sb.pop_front();
                ey = model(it.op, it.a, it.b);
                chk("y32", 64'(bus32.y), 64'(ey));
                chk("y8", 64'(bus8.y), 64'(ey[7:0]));
                chk("yc", 64'(busc.y), 64'(ey[7:0]));
                chk("y1", 64'(bus1.y), 64'(ey[0]));
                chk("y_op", 64'(bus8.y_op), 64'(it.op));
                chk("min_latency", 64'((cycle - it.t) >= 1), 64'(1));
            end
            ndel++;
        end
        stalled = !rst && bus8.out_valid && !out_ready;
        held = snap();
        @(posedge clk);
        cycle++;
        if (rst) begin
            sb.delete();
            ndel = 0;
        end else if (acc) begin
            it.op = op;
            it.a  = a;
            it.b  = b;
            it.t  = cycle;
            sb.push_back(it);
        end
        hs_acc = !rst && acc;
        @(negedge clk);
        chk("cnt16", 64'(bus8.op_count), 64'(ndel));
        chk("cnt_sat", 64'(busc.op_count), 64'((ndel > 3) ? 3 : ndel));
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nacc;
        int guard;
        logic exp_rdy[5];

        vecs[0] = '{3'd0, 8'hCA, 8'h0F, 8'h0A};
        vecs[1] = '{3'd1, 8'hCA, 8'h0F, 8'hCF};
        vecs[2] = '{3'd2, 8'hCA, 8'h0F, 8'h35};
        vecs[3] = '{3'd3, 8'hCA, 8'h0F, 8'hF5};
        vecs[4] = '{3'd4, 8'hCA, 8'h0F, 8'h30};
        vecs[5] = '{3'd5, 8'hCA, 8'h0F, 8'hC5};
        vecs[6] = '{3'd6, 8'hCA, 8'h0F, 8'h3A};
        vecs[7] = '{3'd7, 8'hCA, 8'h0F, 8'hCA};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 3'd0;
        a = '0;
        b = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus8.out_valid), 64'(0));
        chk("rst_y8", 64'(bus8.y), 64'(0));
        chk("rst_y32", 64'(bus32.y), 64'(0));
        chk("rst_y_op", 64'(bus8.y_op), 64'(0));
        chk("rst_count", 64'(bus8.op_count), 64'(0));
        chk("rst_in_ready", 64'(bus8.in_ready), 64'(1));

        // All eight opcodes, one at a time, exact two-edge latency.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = vecs[i].op;
            a  = {4{vecs[i].a}};
            b  = {4{vecs[i].b}};
            cyc();
            chk("tbl_accept", 64'(hs_acc), 64'(1));
            chk("tbl_not_yet", 64'(bus8.out_valid), 64'(0));
            in_valid = 1'b0;
            cyc();
            chk("tbl_valid", 64'(bus8.out_valid), 64'(1));
            chk("tbl_y", 64'(bus8.y), 64'(vecs[i].y));
            chk("tbl_y_op", 64'(bus8.y_op), 64'(vecs[i].op));
        end
        drain(1);
        chk("tbl_count", 64'(bus8.op_count), 64'(8));
        chk("tbl_count_sat", 64'(busc.op_count), 64'(3));

        // Back-to-back throughput.
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            cyc();
            chk("thru_ready", 64'(hs_rdy), 64'(1));
            if (k >= 2) chk("thru_valid", 64'(bus8.out_valid), 64'(1));
        end
        drain(3);
        chk("thru_count", 64'(bus8.op_count), 64'(24));

        // Backpressure fills both stages, then releases.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            cyc();
            chk("stall_ready", 64'(hs_rdy), 64'(exp_rdy[k]));
        end
        chk("stall_queue", 64'(sb.size()), 64'(2));
        out_ready = 1'b1;
        op = 3'd5;
        a  = $urandom();
        b  = $urandom();
        cyc();
        chk("release_ready", 64'(hs_rdy), 64'(1));
        drain(4);
        chk("stall_count", 64'(bus8.op_count), 64'(27));

        // Random valid/ready toggling.
        nacc = 0;
        guard = 0;
        while (nacc < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            cyc();
            if (hs_acc) nacc++;
            guard++;
        end
        chk("rand_beats", 64'(nacc), 64'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && sb.size() != 0; g++) cyc();
        chk("rand_drained", 64'(sb.size()), 64'(0));

        // Reset with both stages occupied discards everything.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            cyc();
        end
        chk("full_before_rst", 64'(bus8.in_ready), 64'(0));
        rst = 1'b1;
        out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus8.out_valid), 64'(0));
        chk("mrst_count", 64'(bus8.op_count), 64'(0));
        chk("mrst_in_ready", 64'(bus8.in_ready), 64'(1));
        chk("mrst_y", 64'(bus8.y), 64'(0));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("mrst_no_emerge", 64'(bus8.out_valid), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
